// File: rtl/pong_graph_pkg.sv
// rtl/pong_graph_pkg.sv - game geometry, colours and FSM encoding for the Pong pixel generator
package pong_graph_pkg;
    localparam int BALL_SIZE   = 8;
    localparam int BALL_V      = 2;
    localparam int PAD_H       = 72;
    localparam int PAD_V       = 4;
    localparam int SCREEN_W    = 640;
    localparam int SCREEN_H    = 480;
    localparam int MISS_FRAMES = 60;

    // Draw and miss compares use 11 bits so right/bottom edges never wrap
    localparam logic [10:0] X_MAX    = 11'(SCREEN_W - 1);
    localparam logic [10:0] BALL_EXT = 11'(BALL_SIZE - 1);
    localparam logic [10:0] PAD_EXT  = 11'(PAD_H - 1);
    localparam logic [10:0] WALL_XL  = 11'd32;
    localparam logic [10:0] WALL_XR  = 11'd35;
    localparam logic [10:0] PAD_XL   = 11'd600;
    localparam logic [10:0] PAD_XR   = 11'd603;

    localparam logic [9:0] TICK_ROW  = 10'd481;
    localparam logic [9:0] V_BALL    = 10'(BALL_V);
    localparam logic [9:0] V_PAD     = 10'(PAD_V);
    localparam logic [9:0] Y_EXT     = 10'(BALL_SIZE - 1);
    localparam logic [9:0] TOP_LIM   = 10'd1;
    localparam logic [9:0] BOT_LIM   = 10'(SCREEN_H - 2);
    localparam logic [9:0] PAD_Y_MAX = 10'(SCREEN_H - PAD_H);
    localparam logic [9:0] BALL_X0   = 10'd316;
    localparam logic [9:0] BALL_Y0   = 10'd236;
    localparam logic [9:0] PAD_Y0    = 10'd204;
    localparam logic [5:0] MISS_LAST = 6'(MISS_FRAMES - 1);

    localparam logic [11:0] RGB_OFF  = 12'h000;
    localparam logic [11:0] RGB_BALL = 12'hF00;
    localparam logic [11:0] RGB_PAD  = 12'h0F0;
    localparam logic [11:0] RGB_WALL = 12'h00F;
    localparam logic [11:0] RGB_BG   = 12'hFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_MISS = 2'd2
    } state_t;

    function automatic logic in_span(input logic [10:0] v, input logic [10:0] lo,
                                     input logic [10:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction
endpackage

// File: rtl/pong_refresh_tick.sv
// rtl/pong_refresh_tick.sv - one-clock frame tick on entry to scan position (0,481)
module pong_refresh_tick
    import pong_graph_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [9:0] pixel_x_i,
    input  logic [9:0] pixel_y_i,
    output logic       frame_tick_o
);
    logic at_tick_d;
    logic at_tick_q;
    logic at_tick_prev_q;

    assign at_tick_d = (pixel_x_i == 10'd0) && (pixel_y_i == TICK_ROW);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            at_tick_q      <= 1'b0;
            at_tick_prev_q <= 1'b0;
        end else begin
            at_tick_q      <= at_tick_d;
            at_tick_prev_q <= at_tick_q;
        end
    end

    // Pixel is held several clocks, so only the rising edge counts
    assign frame_tick_o = at_tick_q & ~at_tick_prev_q;
endmodule

// File: rtl/pong_graph.sv
// rtl/pong_graph.sv - Pong game state (paddle, ball, FSM) and registered pixel colour
module pong_graph
    import pong_graph_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        video_on,
    input  logic        btn_up,
    input  logic        btn_down,
    output logic [11:0] rgb,
    output logic        hit,
    output logic        miss,
    output logic [7:0]  hit_count
);
    logic        frame_tick;
    state_t      state_q, state_d;
    logic [9:0]  ball_x_q, ball_x_d, ball_y_q, ball_y_d, pad_y_q, pad_y_d;
    logic        dx_neg_q, dx_neg_d, dy_neg_q, dy_neg_d;
    logic [5:0]  miss_cnt_q, miss_cnt_d;
    logic [7:0]  hit_count_q, hit_count_d;
    logic        hit_q, hit_d, miss_q, miss_d;
    logic [11:0] rgb_q, rgb_d;

    pong_refresh_tick u_refresh_tick (
        .clk_i        (clk),
        .rst_ni       (rst),
        .pixel_x_i    (pixel_x),
        .pixel_y_i    (pixel_y),
        .frame_tick_o (frame_tick)
    );

    logic [10:0] px, py, bx, by, ball_r, ball_b, pad_t, pad_b;
    logic [9:0]  ball_b10;
    logic        pad_overlap;

    assign px     = {1'b0, pixel_x};
    assign py     = {1'b0, pixel_y};
    assign bx     = {1'b0, ball_x_q};
    assign by     = {1'b0, ball_y_q};
    assign ball_r = bx + BALL_EXT;
    assign ball_b = by + BALL_EXT;
    assign pad_t  = {1'b0, pad_y_q};
    assign pad_b  = pad_t + PAD_EXT;
    // Bottom test wraps in 10 bits so a ball that overshot the top (y=1022) bounces back
    assign ball_b10    = ball_y_q + Y_EXT;
    assign pad_overlap = (by <= pad_b) && (ball_b >= pad_t);

    always_comb begin
        state_d     = state_q;
        ball_x_d    = ball_x_q;
        ball_y_d    = ball_y_q;
        dx_neg_d    = dx_neg_q;
        dy_neg_d    = dy_neg_q;
        pad_y_d     = pad_y_q;
        miss_cnt_d  = miss_cnt_q;
        hit_count_d = hit_count_q;
        hit_d       = 1'b0;
        miss_d      = 1'b0;
        if (frame_tick) begin
            if (btn_up && !btn_down) begin
                pad_y_d = (pad_y_q >= V_PAD) ? pad_y_q - V_PAD : 10'd0;
            end else if (btn_down && !btn_up) begin
                pad_y_d = (pad_y_q > PAD_Y_MAX - V_PAD) ? PAD_Y_MAX : pad_y_q + V_PAD;
            end
            case (state_q)
                ST_IDLE: begin
                    if (btn_up || btn_down) begin
                        state_d     = ST_PLAY;
                        hit_count_d = 8'd0;
                    end
                end
                ST_PLAY: begin
                    if (ball_r > X_MAX) begin
                        state_d    = ST_MISS;
                        miss_d     = 1'b1;
                        miss_cnt_d = 6'd0;
                    end else begin
                        ball_x_d = dx_neg_q ? ball_x_q - V_BALL : ball_x_q + V_BALL;
                        ball_y_d = dy_neg_q ? ball_y_q - V_BALL : ball_y_q + V_BALL;
                        if (ball_y_q <= TOP_LIM) begin
                            dy_neg_d = 1'b0;
                        end else if (ball_b10 >= BOT_LIM) begin
                            dy_neg_d = 1'b1;
                        end
                        if (bx <= WALL_XR) begin
                            dx_neg_d = 1'b0;
                        end else if (!dx_neg_q && in_span(ball_r, PAD_XL, PAD_XR) && pad_overlap) begin
                            dx_neg_d = 1'b1;
                            hit_d    = 1'b1;
                            if (hit_count_q != 8'hFF) begin
                                hit_count_d = hit_count_q + 8'd1;
                            end
                        end
                    end
                end
                ST_MISS: begin
                    if (miss_cnt_q == MISS_LAST) begin
                        state_d    = ST_IDLE;
                        miss_cnt_d = 6'd0;
                        ball_x_d   = BALL_X0;
                        ball_y_d   = BALL_Y0;
                        dx_neg_d   = 1'b1;
                        dy_neg_d   = 1'b0;
                    end else begin
                        miss_cnt_d = miss_cnt_q + 6'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    logic ball_on, pad_on, wall_on;
    assign ball_on = (state_q != ST_MISS) && in_span(px, bx, ball_r) && in_span(py, by, ball_b);
    assign pad_on  = in_span(px, PAD_XL, PAD_XR) && in_span(py, pad_t, pad_b);
    assign wall_on = in_span(px, WALL_XL, WALL_XR);

    always_comb begin
        rgb_d = RGB_OFF;
        if (video_on) begin
            if (ball_on)      rgb_d = RGB_BALL;
            else if (pad_on)  rgb_d = RGB_PAD;
            else if (wall_on) rgb_d = RGB_WALL;
            else              rgb_d = RGB_BG;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            ball_x_q    <= BALL_X0;
            ball_y_q    <= BALL_Y0;
            dx_neg_q    <= 1'b1;
            dy_neg_q    <= 1'b0;
            pad_y_q     <= PAD_Y0;
            miss_cnt_q  <= 6'd0;
            hit_count_q <= 8'd0;
            hit_q       <= 1'b0;
            miss_q      <= 1'b0;
            rgb_q       <= RGB_OFF;
        end else begin
            state_q     <= state_d;
            ball_x_q    <= ball_x_d;
            ball_y_q    <= ball_y_d;
            dx_neg_q    <= dx_neg_d;
            dy_neg_q    <= dy_neg_d;
            pad_y_q     <= pad_y_d;
            miss_cnt_q  <= miss_cnt_d;
            hit_count_q <= hit_count_d;
            hit_q       <= hit_d;
            miss_q      <= miss_d;
            rgb_q       <= rgb_d;
        end
    end

    assign rgb       = rgb_q;
    assign hit       = hit_q;
    assign miss      = miss_q;
    assign hit_count = hit_count_q;
endmodule
